// File: rtl/pcd8544_spi_receiver_if.sv
// Serial link between an LCD SPI master and a PCD8544-style responder.
//   sclk    : serial clock, data sampled on rising edge
//   mosi    : serial data, MSB first
//   sce     : chip enable, active-low
//   dc      : 0 = command byte, 1 = data byte
//   lcd_rst : LCD reset, active-low
interface pcd8544_spi_receiver_if;
  logic sclk;
  logic mosi;
  logic sce;
  logic dc;
  logic lcd_rst;

  modport master (output sclk, mosi, sce, dc, lcd_rst);
  modport slave  (input  sclk, mosi, sce, dc, lcd_rst);
endinterface

// File: rtl/pcd8544_spi_receiver.sv
// PCD8544 (84x48 LCD) controller model: oversamples the serial link in the
// system clock domain, assembles bytes, decodes commands and writes data
// bytes into a 504x8 display RAM with address auto-increment.
// Ports:
//   i_clk, i_rst_n       : system clock, async active-low reset
//   spi (slave modport)  : sclk/mosi/sce/dc/lcd_rst from the master
//   i_rd_addr/o_rd_data  : RAM read port, 1-cycle latency, read-before-write
//   o_rx_valid/_byte/_dc : received-byte pulse, byte and its dc bit
//   o_wr_en/o_wr_addr    : RAM write strobe and address (data bytes)
//   o_x_addr/o_y_addr    : current column / bank
//   o_h_mode, o_v_mode, o_pd, o_disp_mode, o_vop, o_bias, o_tc : controller state
//   o_cmd_err            : pulse on illegal or out-of-range command
module pcd8544_spi_receiver #(
  parameter int unsigned X_MAX       = 84,
  parameter int unsigned Y_MAX       = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  pcd8544_spi_receiver_if.slave spi,
  input  logic [8:0]           i_rd_addr,
  output logic [7:0]           o_rd_data,
  output logic                 o_rx_valid,
  output logic [7:0]           o_rx_byte,
  output logic                 o_rx_dc,
  output logic                 o_wr_en,
  output logic [8:0]           o_wr_addr,
  output logic [6:0]           o_x_addr,
  output logic [2:0]           o_y_addr,
  output logic                 o_h_mode,
  output logic                 o_v_mode,
  output logic                 o_pd,
  output logic [1:0]           o_disp_mode,
  output logic [6:0]           o_vop,
  output logic [2:0]           o_bias,
  output logic [1:0]           o_tc,
  output logic                 o_cmd_err
);

  localparam int unsigned DEPTH = X_MAX * Y_MAX;
  localparam logic [6:0] X_LAST = 7'(X_MAX - 1);
  localparam logic [2:0] Y_LAST = 3'(Y_MAX - 1);

  // {lcd_rst, dc, sce, mosi, sclk} through the synchronizer chain
  logic [4:0] r_sync [SYNC_STAGES];
  logic       r_sclk_d;
  logic       w_lcd_rst, w_dc, w_sce, w_mosi, w_sclk, w_sclk_rise;

  logic [7:0] r_shift;
  logic [2:0] r_cnt;
  logic [8:0] w_wr_addr;
  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_sclk_d <= 1'b0;
    end else begin
      r_sync[0] <= {spi.lcd_rst, spi.dc, spi.sce, spi.mosi, spi.sclk};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_sclk_d <= w_sclk;
    end
  end

  assign {w_lcd_rst, w_dc, w_sce, w_mosi, w_sclk} = r_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;

  assign w_wr_addr = ({6'd0, o_y_addr} * 9'(X_MAX)) + {2'd0, o_x_addr};
  assign o_wr_en   = o_rx_valid & o_rx_dc;
  assign o_wr_addr = w_wr_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      o_rx_valid  <= 1'b0;
      o_rx_byte   <= '0;
      o_rx_dc     <= 1'b0;
      o_x_addr    <= '0;
      o_y_addr    <= '0;
      o_h_mode    <= 1'b0;
      o_v_mode    <= 1'b0;
      o_pd        <= 1'b1;
      o_disp_mode <= '0;
      o_vop       <= '0;
      o_bias      <= '0;
      o_tc        <= '0;
      o_cmd_err   <= 1'b0;
    end else if (!w_lcd_rst) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      o_rx_valid  <= 1'b0;
      o_rx_byte   <= '0;
      o_rx_dc     <= 1'b0;
      o_x_addr    <= '0;
      o_y_addr    <= '0;
      o_h_mode    <= 1'b0;
      o_v_mode    <= 1'b0;
      o_pd        <= 1'b1;
      o_disp_mode <= '0;
      o_vop       <= '0;
      o_bias      <= '0;
      o_tc        <= '0;
      o_cmd_err   <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      o_cmd_err  <= 1'b0;

      // Deselect aborts any partial byte; counter wraps to 0 after bit 8.
      if (w_sce) begin
        r_cnt <= '0;
      end else if (w_sclk_rise) begin
        r_shift <= {r_shift[6:0], w_mosi};
        r_cnt   <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          o_rx_valid <= 1'b1;
          o_rx_byte  <= {r_shift[6:0], w_mosi};
          o_rx_dc    <= w_dc;
        end
      end

      if (o_rx_valid) begin
        if (o_rx_dc) begin
          if (o_v_mode) begin
            if (o_y_addr == Y_LAST) begin
              o_y_addr <= '0;
              o_x_addr <= (o_x_addr == X_LAST) ? '0 : o_x_addr + 7'd1;
            end else begin
              o_y_addr <= o_y_addr + 3'd1;
            end
          end else begin
            if (o_x_addr == X_LAST) begin
              o_x_addr <= '0;
              o_y_addr <= (o_y_addr == Y_LAST) ? '0 : o_y_addr + 3'd1;
            end else begin
              o_x_addr <= o_x_addr + 7'd1;
            end
          end
        end else if (o_rx_byte == 8'h00) begin
          // NOP
        end else if (o_rx_byte[7:3] == 5'b00100) begin
          o_pd     <= o_rx_byte[2];
          o_v_mode <= o_rx_byte[1];
          o_h_mode <= o_rx_byte[0];
        end else if (!o_h_mode) begin
          if ({o_rx_byte[7:3], o_rx_byte[1]} == 6'b000010) begin
            o_disp_mode <= {o_rx_byte[2], o_rx_byte[0]};
          end else if (o_rx_byte[7:3] == 5'b01000) begin
            if (32'(o_rx_byte[2:0]) < Y_MAX) o_y_addr <= o_rx_byte[2:0];
            else                             o_cmd_err <= 1'b1;
          end else if (o_rx_byte[7]) begin
            if (32'(o_rx_byte[6:0]) < X_MAX) o_x_addr <= o_rx_byte[6:0];
            else                             o_cmd_err <= 1'b1;
          end else begin
            o_cmd_err <= 1'b1;
          end
        end else begin
          if (o_rx_byte[7:2] == 6'b000001) begin
            o_tc <= o_rx_byte[1:0];
          end else if (o_rx_byte[7:3] == 5'b00010) begin
            o_bias <= o_rx_byte[2:0];
          end else if (o_rx_byte[7]) begin
            o_vop <= o_rx_byte[6:0];
          end else begin
            o_cmd_err <= 1'b1;
          end
        end
      end
    end
  end

  // Display RAM is never cleared by either reset.
  always_ff @(posedge i_clk) begin
    if (o_wr_en) r_mem[o_wr_addr] <= o_rx_byte;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_rd_data <= '0;
    else          o_rd_data <= r_mem[i_rd_addr];
  end

endmodule
